// File: rtl/chan_512_packet_avgiq_accum.sv
// Channel tracker and 2^LOG2_AVG-sample I/Q averager feeding the avgIQ snapshot BRAM.
// Define AVGIQ_ROUND_EN for round-half-up with positive saturation instead of floor truncation.
module chan_512_packet_avgiq_accum #(
    parameter int unsigned NCHAN    = 512,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOG2_AVG = 4,
    parameter int unsigned ABITS    = 10
) (
    input  logic                     user_clk,
    input  logic                     user_rst,
    input  logic                     sync_in,
    input  logic [DW-1:0]            i_in,
    input  logic [DW-1:0]            q_in,
    input  logic                     run,
    input  logic [$clog2(NCHAN)-1:0] ch_sel,
    output logic [ABITS-1:0]         bram_addr,
    output logic [2*DW-1:0]          bram_din,
    output logic                     bram_we,
    output logic                     avg_done,
    output logic [31:0]              addr_out
);

    localparam int unsigned CW   = $clog2(NCHAN);
    localparam int unsigned AW   = DW + LOG2_AVG;
    localparam int unsigned NAVG = 1 << LOG2_AVG;

`ifdef AVGIQ_ROUND_EN
    localparam logic signed [AW:0] RND = (AW+1)'(NAVG / 2);
    localparam logic signed [AW:0] SAT = (AW+1)'((1 << (DW - 1)) - 1);
`endif

    typedef enum logic [1:0] {StIdle, StAccum, StWrite} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         next_ch_q, next_ch_d;
    logic                  synced_q, synced_d;
    logic [CW-1:0]         ch_lat_q, ch_lat_d;
    logic signed [AW-1:0]  acc_i_q, acc_i_d;
    logic signed [AW-1:0]  acc_q_q, acc_q_d;
    logic [LOG2_AVG:0]     cnt_q, cnt_d;
    logic [ABITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0]      bram_addr_q, bram_addr_d;
    logic [2*DW-1:0]       bram_din_q, bram_din_d;
    logic                  bram_we_q, bram_we_d;
    logic [31:0]           addr_out_q, addr_out_d;

    logic [CW-1:0]         cur_ch;
    logic                  qualify;
    logic signed [AW-1:0]  i_ext, q_ext, sum_i, sum_q;

    function automatic logic [DW-1:0] avg_of(input logic signed [AW-1:0] acc);
`ifdef AVGIQ_ROUND_EN
        logic signed [AW:0] sh;
        sh = ((AW+1)'(acc) + RND) >>> LOG2_AVG;
        if (sh > SAT) begin
            avg_of = DW'(SAT);
        end else begin
            avg_of = DW'(sh);
        end
`else
        logic signed [AW-1:0] sh;
        sh = acc >>> LOG2_AVG;
        avg_of = DW'(sh);
`endif
    endfunction

    // cur_ch is the channel of the sample presented this cycle; the register holds its successor.
    assign cur_ch    = sync_in ? '0 : next_ch_q;
    assign next_ch_d = (cur_ch == CW'(NCHAN - 1)) ? '0 : cur_ch + 1'b1;
    assign synced_d  = synced_q | sync_in;
    assign qualify   = synced_q && (cur_ch == ch_lat_q);

    assign i_ext = AW'($signed(i_in));
    assign q_ext = AW'($signed(q_in));
    assign sum_i = acc_i_q + i_ext;
    assign sum_q = acc_q_q + q_ext;

    always_comb begin
        state_d     = state_q;
        ch_lat_d    = ch_lat_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = 1'b0;
        addr_out_d  = addr_out_q;

        unique case (state_q)
            StIdle: begin
                if (run && synced_q) begin
                    ch_lat_d = ch_sel;
                    acc_i_d  = '0;
                    acc_q_d  = '0;
                    cnt_d    = '0;
                    state_d  = StAccum;
                end
            end
            StAccum: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (qualify) begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                    cnt_d   = cnt_q + 1'b1;
                    // Result is registered on this edge so the write lands in the next cycle.
                    if (cnt_q == (LOG2_AVG+1)'(NAVG - 1)) begin
                        bram_we_d   = 1'b1;
                        bram_din_d  = {avg_of(sum_i), avg_of(sum_q)};
                        bram_addr_d = wr_ptr_q;
                        state_d     = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_out_d     = 32'(bram_addr_q);
                addr_out_d[31] = 1'b1;
                wr_ptr_d       = wr_ptr_q + 1'b1;
                if (run) begin
                    ch_lat_d = ch_sel;
                    acc_i_d  = '0;
                    acc_q_d  = '0;
                    cnt_d    = '0;
                    state_d  = StAccum;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= StIdle;
            next_ch_q   <= '0;
            synced_q    <= 1'b0;
            ch_lat_q    <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            addr_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_ch_q   <= next_ch_d;
            synced_q    <= synced_d;
            ch_lat_q    <= ch_lat_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_we_q   <= bram_we_d;
            addr_out_q  <= addr_out_d;
        end
    end

    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign bram_we   = bram_we_q;
    assign avg_done  = bram_we_q;
    assign addr_out  = addr_out_q;

endmodule

// File: doc/chan_512_packet_avgiq_accum.md
# chan_512_packet_avgiq_accum

Averaging stage directly upstream of the avgIQ address software register in the 512-channel packet design. It tracks the channel index of the streaming I/Q data, accumulates 2^LOG2_AVG consecutive samples of one selected channel, and writes each averaged I/Q word into a snapshot BRAM. It publishes the address of the most recently written word on a 32-bit output that drives the register's `user_data_in`, so the PPC can read the buffer up to that point.

## Interface
- `NCHAN`, 512: channels per frame; channel counter width is log2(NCHAN) = 9.
- `DW`, 16: signed width of the I and Q inputs.
- `LOG2_AVG`, 4: log2 of the number of samples per average, legal range 0..8.
- `ABITS`, 10: snapshot buffer address width (depth 1024).

- `user_clk` in 1: single clock for all logic.
- `user_rst` in 1: synchronous, active-high reset.
- `sync_in` in 1: pulse; marks channel 0 on `i_in`/`q_in` in the same cycle.
- `i_in` in DW: signed I sample, one channel per clock.
- `q_in` in DW: signed Q sample.
- `run` in 1: level; enables averaging.
- `ch_sel` in 9: channel to average.
- `bram_addr` out ABITS: snapshot write address.
- `bram_din` out 2*DW: {I_avg, Q_avg}, with I in the upper half.
- `bram_we` out 1: write strobe, one cycle per average.
- `avg_done` out 1: pulse, coincident with `bram_we`.
- `addr_out` out 32: {valid, 21'b0, last written address, zero-extended}; feeds the avgIQ_addr register.

## Operation
- Channel counter `chan_cnt`:
  - loads 0 when `sync_in`=1; otherwise increments mod NCHAN.
  - a flag `synced` sets on the first `sync_in` after reset.
  - no sample qualifies while `synced`=0.
- A sample qualifies in a cycle when `synced`=1 and `chan_cnt` (or 0 if `sync_in`=1) equals the latched channel.
- State machine:
  - IDLE: when `run`=1 and `synced`=1, latch `ch_sel` into `ch_lat`, clear both accumulators and the sample count, go to ACCUM.
  - ACCUM: on each qualifying sample, add the sign-extended I and Q to accumulators of width DW+LOG2_AVG and increment the count. When the count reaches 2^LOG2_AVG, go to WRITE.
  - WRITE (one cycle): assert `bram_we` and `avg_done`; `bram_din` = each accumulator arithmetic-shifted right by LOG2_AVG, taking the low DW bits (floor). Update `addr_out` and increment `wr_ptr`. If `run`=1, re-latch `ch_sel`, clear the accumulators and go to ACCUM; otherwise go to IDLE.
- `ch_sel` changes take effect only at an average boundary.
- `run` deasserted in ACCUM: go to IDLE on the next edge and discard the partial sum; `wr_ptr` and `addr_out` are unchanged.
- `wr_ptr` wraps from 2^ABITS-1 to 0. The valid bit (`addr_out[31]`) stays set after wrap.
- `sync_in` arriving mid-frame reloads `chan_cnt` only; accumulation state is untouched.
- Reset mid-average:
  - discards all state;
  - `wr_ptr` returns to 0;
  - `addr_out` clears, including the valid bit.

## Timing
- Reset values:
  - outputs: `bram_addr`=0, `bram_din`=0, `bram_we`=0, `avg_done`=0, `addr_out`=0.
  - internal: state IDLE, `synced`=0.
- All outputs are registered.
- The WRITE cycle (`bram_we`=1) is the clock cycle immediately after the edge that captured the final qualifying sample.
- `addr_out` updates on the same edge that ends `bram_we`, so it changes only after the BRAM word has been written.
- `bram_addr` holds the last written address between writes.
- Minimum spacing between writes is NCHAN×2^LOG2_AVG cycles, so WRITE can never collide with a qualifying sample when NCHAN ≥ 2.

## Configuration
- `AVGIQ_ROUND_EN` defined:
  - add 2^(LOG2_AVG-1) to each accumulator before the shift (round half up);
  - a result above the DW-bit signed maximum saturates to 2^(DW-1)-1;
  - no effect when LOG2_AVG=0.
- Undefined: plain floor truncation, with no saturation logic.

## Test plan
- Reset, `sync_in` every 512 cycles, `run`=1, `ch_sel`=5, I=100 and Q=-100 on channel 5 (others 0), LOG2_AVG=4 -> first `bram_we` at `bram_addr`=0 with `bram_din`={16'd100, -16'd100}; `addr_out`=0x80000000 one cycle later.
- Channel 5 I samples alternating 1 and 2 (sum 24/16=1.5) -> floor build writes I=1; build with `AVGIQ_ROUND_EN` writes I=2.
- `ch_sel` changed from 5 to 7 mid-average -> current average completes on channel 5; the next average uses channel 7.
- Run 1025 averages -> `bram_addr` wraps to 0 on write 1025; `addr_out`=0x80000000 with the valid bit still set.
- `run` dropped after 8 of 16 samples, then reasserted -> no write from the partial average; the next write is a full 16-sample average at the next address.
- `user_rst` asserted during ACCUM -> all outputs 0 next cycle; no write occurs until a new `sync_in` is seen.
